// File: rtl/stft_pkg.sv
// stft_pkg: shared types and default geometry for the STFT frame buffer.
package stft_pkg;
    localparam int DEF_SAMPLE_W  = 16;
    localparam int DEF_NUM_CH    = 1;
    localparam int DEF_FRAME_LEN = 512;
    localparam int DEF_HOP       = 256;
    localparam int DEPTH         = 2 * DEF_FRAME_LEN;
    localparam int PTR_W         = $clog2(DEPTH) + 1;
    typedef logic [DEF_NUM_CH*DEF_SAMPLE_W-1:0] sample_t;
    typedef enum logic [1:0] {FILL, READY, READ} fb_state_t;
endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port RAM with registered 1-cycle read, block-RAM inferable.
module fb_ram #(
    parameter int W  = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/stft_frame_buffer.sv
// stft_frame_buffer: circular capture store presenting overlapping frames (FRAME_LEN, HOP).
// Define FRAME_BUF_STATS_EN to add ovr_count/frame_count statistics ports.
module stft_frame_buffer
    import stft_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int HOP       = DEF_HOP
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_vld,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
    input  logic                       flush,
    output logic                       frame_rdy,
    input  logic                       rd_en,
    output logic [NUM_CH*SAMPLE_W-1:0] rd_data,
    output logic                       rd_vld,
    output logic                       rd_last,
`ifdef FRAME_BUF_STATS_EN
    output logic [15:0]                ovr_count,
    output logic [15:0]                frame_count,
`endif
    output logic                       overrun
);
    localparam int W         = NUM_CH * SAMPLE_W;
    localparam int MEM_DEPTH = 2 * FRAME_LEN;
    localparam int PW        = $clog2(MEM_DEPTH) + 1;
    localparam int AW        = PW - 1;
    localparam int CW        = $clog2(FRAME_LEN);

    fb_state_t     state, state_nxt;
    logic [PW-1:0] wr_ptr, base_ptr, rd_ptr, wr_ptr_nxt, base_ptr_nxt, rd_addr, avail, avail_nxt;
    logic [CW-1:0] rd_cnt, cnt_cur;
    logic          drop, wr_ok, accept, last;
    logic [W-1:0]  ram_q;

    always_comb begin
        avail        = wr_ptr - base_ptr;
        drop         = sample_vld && (avail == PW'(MEM_DEPTH));
        wr_ok        = sample_vld && !drop;
        accept       = rd_en && (state != FILL);
        rd_addr      = (state == READ) ? rd_ptr : base_ptr;
        cnt_cur      = (state == READ) ? rd_cnt : '0;
        last         = accept && (cnt_cur == CW'(FRAME_LEN - 1));
        wr_ptr_nxt   = wr_ptr + PW'(wr_ok);
        base_ptr_nxt = base_ptr + (last ? PW'(HOP) : '0);
        avail_nxt    = wr_ptr_nxt - base_ptr_nxt;
        // readiness is re-evaluated whenever no frame is mid-readout
        state_nxt    = (state == FILL || last) ? ((avail_nxt >= PW'(FRAME_LEN)) ? READY : FILL)
                     : accept ? READ : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            wr_ptr   <= '0;
            base_ptr <= '0;
            rd_ptr   <= '0;
            rd_cnt   <= '0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            overrun  <= 1'b0;
        end else if (flush) begin
            state    <= FILL;
            wr_ptr   <= '0;
            base_ptr <= '0;
            rd_ptr   <= '0;
            rd_cnt   <= '0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            base_ptr <= base_ptr_nxt;
            if (accept) begin
                rd_ptr <= rd_addr + 1'b1;
                rd_cnt <= cnt_cur + 1'b1;
            end
            rd_vld   <= accept;
            rd_last  <= last;
            overrun  <= drop;
        end
    end

`ifdef FRAME_BUF_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_count   <= '0;
            frame_count <= '0;
        end else if (flush) begin
            ovr_count   <= '0;
            frame_count <= '0;
        end else begin
            if (drop && ovr_count != 16'hFFFF) ovr_count <= ovr_count + 16'd1;
            if (last) frame_count <= frame_count + 16'd1;
        end
    end
`endif

    assign frame_rdy = (state != FILL);
    assign rd_data   = rd_vld ? ram_q : '0;

    fb_ram #(.W(W), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_ok && !flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (sample_in),
        .re    (accept && !flush),
        .raddr (rd_addr[AW-1:0]),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_stft_frame_buffer.sv
// tb_stft_frame_buffer: randomized scenarios against an absolute-sample-index frame model.
module tb_stft_frame_buffer;
    localparam int FL = 8, HP = 4, NC = 2, SW = 16;

    logic        clk = 0, rst_n = 0, sample_vld = 0, flush = 0, rd_en = 0;
    logic [31:0] sample_in = '0, rd_data;
    logic        frame_rdy, rd_vld, rd_last, overrun;
`ifdef FRAME_BUF_STATS_EN
    logic [15:0] ovr_count, frame_count;
`endif

    stft_frame_buffer #(.SAMPLE_W(SW), .NUM_CH(NC), .FRAME_LEN(FL), .HOP(HP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_vld (sample_vld),
        .sample_in  (sample_in),
        .flush      (flush),
        .frame_rdy  (frame_rdy),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .rd_last    (rd_last),
`ifdef FRAME_BUF_STATS_EN
        .ovr_count  (ovr_count),
        .frame_count(frame_count),
`endif
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int          vectors = 0, errors = 0;
    logic [31:0] mem_m [int];
    int          wr_n, base_n, m_idx, frames;
    bit          m_rdy, e_vld, e_last, e_ovr;
    logic [31:0] e_data;

    function automatic logic [31:0] samp(int n);
        return {16'(n), 16'(~n)};
    endfunction

    task automatic m_reset();
        mem_m.delete();
        wr_n = 0; base_n = 0; m_idx = 0; frames = 0;
        m_rdy = 0; e_vld = 0; e_last = 0; e_ovr = 0; e_data = '0;
    endtask

    // one clock: sample n=wr_n offered when v; model tracks absolute sample indices
    task automatic cycle(input bit v, input bit r);
        bit acc;
        sample_vld = v; sample_in = samp(wr_n); rd_en = r;
        @(posedge clk);
        e_ovr  = v && (wr_n - base_n == 2 * FL);
        acc    = r && m_rdy;
        e_vld  = acc; e_last = 0; e_data = '0;
        if (acc) begin
            e_data = mem_m[base_n + m_idx];
            e_last = (m_idx == FL - 1);
            if (e_last) begin m_idx = 0; base_n += HP; frames++; end
            else m_idx++;
        end
        if (v && !e_ovr) begin mem_m[wr_n] = samp(wr_n); wr_n++; end
        m_rdy = (m_idx > 0) || (wr_n - base_n >= FL);
        #1;
        sample_vld = 0; rd_en = 0;
    endtask

    task automatic do_flush(input bit v, input bit r);
        sample_vld = v; rd_en = r; flush = 1;
        @(posedge clk); #1;
        flush = 0; sample_vld = 0; rd_en = 0;
        m_reset();
    endtask

    task automatic test_reset();
        m_reset();
        #12;
        vectors++;
        if ({rd_vld, rd_last, frame_rdy, overrun, rd_data} !== 36'h0) begin
            errors++; $display("FAIL reset: got vld=%b last=%b rdy=%b ovr=%b data=%h, want all 0", rd_vld, rd_last, frame_rdy, overrun, rd_data);
        end
        rst_n = 1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 2 * FL; i++) begin
            cycle(i < FL, i >= FL);
            vectors++;
            if ({rd_vld, rd_last, frame_rdy, overrun, rd_vld ? rd_data : 32'h0} !== {e_vld, e_last, m_rdy, e_ovr, e_data}) begin
                errors++; $display("FAIL basic[%0d]: got %b%b%b%b %h, want %b%b%b%b %h", i, rd_vld, rd_last, frame_rdy, overrun, rd_data, e_vld, e_last, m_rdy, e_ovr, e_data);
            end
        end
    endtask

    task automatic test_overlap();
        for (int i = 0; i < HP + FL; i++) begin
            cycle(i < HP, i >= HP);
            vectors++;
            if ({rd_vld, rd_last, frame_rdy, overrun, rd_vld ? rd_data : 32'h0} !== {e_vld, e_last, m_rdy, e_ovr, e_data}) begin
                errors++; $display("FAIL overlap[%0d]: got %b%b%b%b %h, want %b%b%b%b %h", i, rd_vld, rd_last, frame_rdy, overrun, rd_data, e_vld, e_last, m_rdy, e_ovr, e_data);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < HP; i++) cycle(1, 0);
        do_flush(1, 1);
        vectors++;
        if ({rd_vld, rd_last, frame_rdy, overrun} !== 4'b0) begin
            errors++; $display("FAIL flush: got vld=%b last=%b rdy=%b ovr=%b, want 0000", rd_vld, rd_last, frame_rdy, overrun);
        end
    endtask

    task automatic test_concurrent();
        int t = 0;
        int ph = $urandom_range(0, 2);
        do_flush(0, 0);
        while (frames < 6 && t < 1000) begin
            cycle((t + ph) % 3 == 0, 1);
            vectors++;
            if ({rd_vld, rd_last, frame_rdy, overrun, rd_vld ? rd_data : 32'h0} !== {e_vld, e_last, m_rdy, 1'b0, e_data}) begin
                errors++; $display("FAIL concurrent[%0d]: got %b%b%b%b %h, want %b%b%b0 %h", t, rd_vld, rd_last, frame_rdy, overrun, rd_data, e_vld, e_last, m_rdy, e_data);
            end
            t++;
        end
        vectors++;
        if (frames < 6) begin errors++; $display("FAIL concurrent_timeout: got %0d frames, want 6", frames); end
    endtask

    task automatic test_overrun();
        int povr = 0;
        do_flush(0, 0);
        for (int i = 0; i < 2 * FL + 1 + FL; i++) begin
            cycle(i <= 2 * FL, i > 2 * FL);
            povr += overrun;
            vectors++;
            if ({rd_vld, rd_last, frame_rdy, overrun, rd_vld ? rd_data : 32'h0} !== {e_vld, e_last, m_rdy, e_ovr, e_data}) begin
                errors++; $display("FAIL overrun[%0d]: got %b%b%b%b %h, want %b%b%b%b %h", i, rd_vld, rd_last, frame_rdy, overrun, rd_data, e_vld, e_last, m_rdy, e_ovr, e_data);
            end
        end
        vectors++;
        if (povr != 1) begin errors++; $display("FAIL overrun_pulses: got %0d, want 1", povr); end
`ifdef FRAME_BUF_STATS_EN
        vectors++;
        if (ovr_count !== 16'd1) begin errors++; $display("FAIL ovr_count: got %0d, want 1", ovr_count); end
`endif
    endtask

    task automatic test_wrap();
        int t = 0;
        do_flush(0, 0);
        while (frames < 40 && t < 5000) begin
            cycle($urandom_range(0, 1) == 1 && (wr_n - base_n < 2 * FL), $urandom_range(0, 3) != 0);
            vectors++;
            if ({rd_vld, rd_last, frame_rdy, overrun, rd_vld ? rd_data : 32'h0} !== {e_vld, e_last, m_rdy, e_ovr, e_data}) begin
                errors++; $display("FAIL wrap[%0d]: got %b%b%b%b %h, want %b%b%b%b %h", t, rd_vld, rd_last, frame_rdy, overrun, rd_data, e_vld, e_last, m_rdy, e_ovr, e_data);
            end
            if (e_last && frames == 40) begin
                vectors++;
                if (rd_data !== samp(163)) begin errors++; $display("FAIL wrap_frame39_last: got %h, want %h", rd_data, samp(163)); end
            end
            t++;
        end
        vectors++;
        if (frames < 40) begin errors++; $display("FAIL wrap_timeout: got %0d frames, want 40", frames); end
`ifdef FRAME_BUF_STATS_EN
        vectors++;
        if (frame_count !== 16'd40) begin errors++; $display("FAIL frame_count: got %0d, want 40", frame_count); end
`endif
    endtask

    task automatic test_reset_mid_read();
        do_flush(0, 0);
        for (int i = 0; i < FL + 3; i++) cycle(i < FL, i >= FL);
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({rd_vld, rd_last, frame_rdy, overrun, rd_data} !== 36'h0) begin
            errors++; $display("FAIL reset_mid: got vld=%b last=%b rdy=%b ovr=%b data=%h, want all 0", rd_vld, rd_last, frame_rdy, overrun, rd_data);
        end
        #3 rst_n = 1;
        m_reset();
        for (int i = 0; i < FL + 1; i++) begin
            cycle(i < FL, i == FL);
            vectors++;
            if ({rd_vld, rd_last, frame_rdy, overrun, rd_vld ? rd_data : 32'h0} !== {e_vld, e_last, m_rdy, e_ovr, e_data}) begin
                errors++; $display("FAIL after_reset[%0d]: got %b%b%b%b %h, want %b%b%b%b %h", i, rd_vld, rd_last, frame_rdy, overrun, rd_data, e_vld, e_last, m_rdy, e_ovr, e_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_flush();
        test_concurrent();
        test_overrun();
        test_wrap();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
